// File: rtl/parity_stream_acc.sv
// parity_stream_acc: reduces a framed valid/ready word stream to an XOR word, parity bit, beat count and overflow flag.
module parity_stream_acc #(
  parameter int WIDTH   = 3,
  parameter int MAX_LEN = 16,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_acc, w_word;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic             r_ovf, r_mode, w_mode, w_beat, w_sat, w_take;
  assign in_ready  = r_state != DONE;
  assign out_valid = r_state == DONE;
  assign w_beat    = in_valid & in_ready;
  assign w_take    = out_valid & out_ready;
  assign w_sat     = r_cnt == CW'(MAX_LEN);
  assign w_cnt_nx  = w_sat ? r_cnt : r_cnt + 1'b1;
  assign w_word    = r_acc ^ in_data;
  // a single-beat frame has no latched mode yet, so take it straight from the port
  assign w_mode    = (r_state == IDLE) ? odd_mode : r_mode;
  always_comb begin
    w_next = r_state;
    if (r_state == DONE) w_next = w_take ? IDLE : DONE;
    else if (w_beat) w_next = in_last ? DONE : ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_mode       <= 1'b0;
      out_word     <= '0;
      out_parity   <= 1'b0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_beat) begin
        r_acc <= w_word;
        r_cnt <= w_cnt_nx;
        r_ovf <= r_ovf | w_sat;
        if (r_state == IDLE) r_mode <= odd_mode;
        if (in_last) begin
          out_word     <= w_word;
          out_parity   <= (^w_word) ^ w_mode;
          out_count    <= w_cnt_nx;
          out_overflow <= r_ovf | w_sat;
        end
      end
      if (w_take) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end
endmodule
